// File: rtl/delay_tap_ctrl.sv
//==============================================================================
// Module      : delay_tap_ctrl
// Description : Tap controller for a step/load programmable delay element.
//               It tracks the element's current tap code and walks it one tap
//               at a time to a requested target. Each MOVE strobe is followed
//               by MOVE_GAP idle cycles. A reload request pulses LOADN so the
//               element reloads DEL_VALUE.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   DELAY_TAP_CTRL_CFLAG_EN - when defined, CFLAG high during a MOVE cycle
//                             aborts the walk: TAP is held, ERR is set and
//                             the operation completes with ACK on the next
//                             cycle. When undefined, CFLAG is ignored and
//                             ERR is tied low.
//
// Parameters:
//   DEL_VALUE  - tap code loaded by LOADN (0..127); also the TAP reset value
//   MOVE_GAP   - idle cycles after every MOVE pulse (1..15)
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RST        in   1  asynchronous active-high reset
//   REQ        in   1  move-to-target request (sampled in IDLE only)
//   TARGET     in   7  requested tap code, captured on REQ acceptance
//   RELOAD     in   1  reload request (sampled in IDLE only, beats REQ)
//   CFLAG      in   1  delay-element limit flag, valid while MOVE is high
//   LOADN      out  1  active-low load strobe
//   MOVE       out  1  single-cycle step strobe
//   DIRECTION  out  1  0 = increase delay, 1 = decrease delay
//   TAP        out  7  tracked tap code
//   BUSY       out  1  operation in progress (through the ACK cycle)
//   ACK        out  1  one-cycle completion pulse
//   ERR        out  1  sticky limit error
//==============================================================================

`default_nettype none

module delay_tap_ctrl #(
   parameter int unsigned DEL_VALUE = 0,
   parameter int unsigned MOVE_GAP  = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ,
   input  logic [6:0] TARGET,
   input  logic       RELOAD,
   input  logic       CFLAG,
   output logic       LOADN,
   output logic       MOVE,
   output logic       DIRECTION,
   output logic [6:0] TAP,
   output logic       BUSY,
   output logic       ACK,
   output logic       ERR
);

   localparam logic [6:0] TAP_INIT = 7'(DEL_VALUE);
   localparam logic [3:0] GAP_LAST = 4'(MOVE_GAP - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      STEP = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t     state;
   logic [6:0] target_q;
   logic [3:0] gap_cnt;
   // Cleared by reset and set on the first clock afterwards, so nothing is
   // accepted on the edge that immediately follows reset release.
   logic       armed;

`ifdef DELAY_TAP_CTRL_CFLAG_EN
   logic       err_q;
   assign ERR = err_q;
`else
   // CFLAG has no function in this build.
   logic unused_cflag;
   assign unused_cflag = CFLAG;
   assign ERR          = 1'b0;
`endif

   // Every output is registered and assigned together with the next state,
   // so MOVE is high exactly in STEP, LOADN low exactly in LOAD and ACK high
   // exactly in DONE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         TAP       <= TAP_INIT;
         target_q  <= TAP_INIT;
         gap_cnt   <= 4'd0;
         armed     <= 1'b0;
         LOADN     <= 1'b1;
         MOVE      <= 1'b0;
         DIRECTION <= 1'b0;
         BUSY      <= 1'b0;
         ACK       <= 1'b0;
`ifdef DELAY_TAP_CTRL_CFLAG_EN
         err_q     <= 1'b0;
`endif
      end else begin
         armed <= 1'b1;
         // Strobes default to inactive; the state branches raise them.
         LOADN <= 1'b1;
         MOVE  <= 1'b0;
         ACK   <= 1'b0;

         case (state)
            IDLE: begin
               if (armed) begin
                  if (RELOAD) begin
                     state <= LOAD;
                     LOADN <= 1'b0;
                     BUSY  <= 1'b1;
                  end else if (REQ) begin
                     target_q  <= TARGET;
                     BUSY      <= 1'b1;
                     // Direction is fixed for the whole walk.
                     DIRECTION <= (TARGET < TAP);
`ifdef DELAY_TAP_CTRL_CFLAG_EN
                     err_q     <= 1'b0;
`endif
                     if (TARGET == TAP) begin
                        state <= DONE;
                        ACK   <= 1'b1;
                     end else begin
                        state <= STEP;
                        MOVE  <= 1'b1;
                     end
                  end
               end
            end

            LOAD: begin
               TAP   <= TAP_INIT;
               state <= DONE;
               ACK   <= 1'b1;
            end

            STEP: begin
`ifdef DELAY_TAP_CTRL_CFLAG_EN
               // Element at its limit: the step did not happen, so the tap
               // is held and the walk ends without the gap.
               if (CFLAG) begin
                  err_q <= 1'b1;
                  state <= DONE;
                  ACK   <= 1'b1;
               end else
`endif
               begin
                  TAP     <= DIRECTION ? (TAP - 7'd1) : (TAP + 7'd1);
                  state   <= GAP;
                  gap_cnt <= GAP_LAST;
               end
            end

            GAP: begin
               if (gap_cnt == 4'd0) begin
                  if (TAP == target_q) begin
                     state <= DONE;
                     ACK   <= 1'b1;
                  end else begin
                     state <= STEP;
                     MOVE  <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end

            DONE: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
